// File: rtl/reed_pulse_generator.sv
// Reed-contact emulator: derives the wheel revolution interval from speed and
// circumference with a serial restoring divider, then emits one pulse per revolution.
module reed_pulse_generator #(
  parameter int F_CLK     = 2048,
  parameter int MAX_SPEED = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [6:0]  speed,
  input  logic [7:0]  circ,
  output logic        reed,
  output logic        busy,
  output logic [14:0] period,
  output logic [15:0] rev_count
);

  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;

  // 36*F_CLK converts cm/(km/h) into clocks per revolution (scaled by 1000)
  localparam logic [24:0] K_NUM   = 25'(36 * F_CLK);
  localparam logic [6:0]  S_MAX   = 7'(MAX_SPEED);
  localparam logic [4:0]  LAST_IT = 5'd25;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        reed_q, reed_d;
  logic [14:0] period_q, period_d;
  logic [15:0] rev_count_q, rev_count_d;
  logic [14:0] cnt_q, cnt_d;
  logic [6:0]  s_q, s_d;
  logic [7:0]  circ_q, circ_d;
  logic        from_run_q, from_run_d;
  logic [4:0]  it_q, it_d;
  logic [24:0] num_q, num_d;
  logic [16:0] den_q, den_d;
  logic [16:0] rem_q, rem_d;

  logic [17:0] shifted;
  logic [24:0] num_next;
  logic [16:0] rem_next;
  logic        active;
  logic        match;

  // One restoring step: numerator bits shift out the top, quotient bits in at the bottom
  always_comb begin
    shifted = {rem_q, num_q[24]};
    if (shifted >= {1'b0, den_q}) begin
      rem_next = 17'(shifted - {1'b0, den_q});
      num_next = {num_q[23:0], 1'b1};
    end else begin
      rem_next = shifted[16:0];
      num_next = {num_q[23:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    period_d    = period_q;
    s_d         = s_q;
    circ_d      = circ_q;
    from_run_d  = from_run_q;
    it_d        = it_q;
    num_d       = num_q;
    den_d       = den_q;
    rem_d       = rem_q;

    case (state_q)
      IDLE, RUN: begin
        if (load && !busy_q) begin
          s_d        = (speed > S_MAX) ? S_MAX : speed;
          circ_d     = circ;
          state_d    = DIVIDE;
          busy_d     = 1'b1;
          it_d       = 5'd0;
          from_run_d = (state_q == RUN);
        end
      end
      DIVIDE: begin
        if (it_q == 5'd0) begin
          if (s_q == 7'd0 || circ_q == 8'd0) begin
            busy_d     = 1'b0;
            period_d   = 15'd0;
            state_d    = IDLE;
            from_run_d = 1'b0;
          end else begin
            num_d = 25'(circ_q) * K_NUM + 25'(s_q) * 25'd500;
            den_d = 17'(s_q) * 17'd1000;
            rem_d = 17'd0;
            it_d  = 5'd1;
          end
        end else begin
          num_d = num_next;
          rem_d = rem_next;
          if (it_q == LAST_IT) begin
            busy_d     = 1'b0;
            period_d   = num_next[14:0];
            state_d    = RUN;
            from_run_d = 1'b0;
          end else begin
            it_d = it_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pulsing keeps the old period while a re-computation runs in the background
    active = (state_q == RUN) || (state_q == DIVIDE && from_run_q);
    match  = active && (cnt_q >= period_q);
    reed_d = match;
    if (match)       cnt_d = 15'd0;
    else if (active) cnt_d = cnt_q + 15'd1;
    else             cnt_d = 15'd0;
    if (state_d == IDLE) begin
      reed_d = 1'b0;
      cnt_d  = 15'd0;
    end
    rev_count_d = rev_count_q + {15'd0, reed_d};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      reed_q      <= 1'b0;
      period_q    <= 15'd0;
      rev_count_q <= 16'd0;
      cnt_q       <= 15'd0;
      s_q         <= 7'd0;
      circ_q      <= 8'd0;
      from_run_q  <= 1'b0;
      it_q        <= 5'd0;
      num_q       <= 25'd0;
      den_q       <= 17'd0;
      rem_q       <= 17'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      reed_q      <= reed_d;
      period_q    <= period_d;
      rev_count_q <= rev_count_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      circ_q      <= circ_d;
      from_run_q  <= from_run_d;
      it_q        <= it_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
    end
  end

  assign reed      = reed_q;
  assign busy      = busy_q;
  assign period    = period_q;
  assign rev_count = rev_count_q;

endmodule

// File: tb/tb_reed_pulse_generator.sv
// Directed bench for reed_pulse_generator; hand-computed periods, latencies and counts.
module tb_reed_pulse_generator;

  logic        clock, reset, load;
  logic [6:0]  speed;
  logic [7:0]  circ;
  logic        reed, busy;
  logic [14:0] period;
  logic [15:0] rev_count;

  int checks   = 0;
  int failures = 0;

  reed_pulse_generator #(.F_CLK(2048), .MAX_SPEED(99)) dut (
    .clock(clock), .reset(reset), .load(load), .speed(speed), .circ(circ),
    .reed(reed), .busy(busy), .period(period), .rev_count(rev_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [6:0] sp, input logic [7:0] ci);
    load = 1'b1; speed = sp; circ = ci;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Counts busy-high samples (and reed pulses seen meanwhile); stops on the first busy-low sample
  task automatic wait_busy_fall(output int n, output int r);
    n = 0; r = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (reed === 1'b1) r++;
      @(negedge clock);
    end
  endtask

  // Number of clocks from the current sample to the next reed sample
  task automatic wait_reed(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (reed !== 1'b1 && n < 2000);
  endtask

  task automatic count_reeds(input int cycles, output int r);
    r = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (reed === 1'b1) r++;
    end
  endtask

  initial begin
    int n, r;
    reset = 1'b0; load = 1'b0; speed = '0; circ = '0;
    repeat (3) @(negedge clock);
    check("rst_reed", reed, 0);
    check("rst_busy", busy, 0);
    check("rst_period", period, 0);
    check("rst_rev", rev_count, 0);
    reset = 1'b1;
    @(negedge clock);

    // 30 km/h, 200 cm
    do_load(7'd30, 8'd200);
    wait_busy_fall(n, r);
    check("busy_len_30", n, 26);
    check("busy_reed_idle", r, 0);
    check("period_30", period, 492);
    wait_reed(n);
    check("first_gap_30", n, 493);
    check("rev_after_1", rev_count, 1);
    wait_reed(n);
    check("gap_30", n, 493);
    check("rev_after_2", rev_count, 2);

    // stop from RUN
    do_load(7'd0, 8'd200);
    check("stop_busy_hi", busy, 1);
    @(negedge clock);
    check("stop_busy_lo", busy, 0);
    check("stop_period", period, 0);
    count_reeds(1200, r);
    check("stop_no_reed", r, 0);
    check("stop_rev_frozen", rev_count, 2);

    // speed clamp
    do_load(7'd120, 8'd255);
    wait_busy_fall(n, r);
    check("busy_len_clamp", n, 26);
    check("period_clamp", period, 190);
    wait_reed(n);
    check("first_gap_clamp", n, 191);
    wait_reed(n);
    check("gap_clamp", n, 191);
    check("rev_clamp", rev_count, 4);

    // load while busy is ignored
    do_load(7'd0, 8'd0);
    @(negedge clock);
    check("circ0_stop", busy, 0);
    do_load(7'd30, 8'd200);
    repeat (4) @(negedge clock);
    load = 1'b1; speed = 7'd10; circ = 8'd200;
    @(negedge clock);
    load = 1'b0;
    wait_busy_fall(n, r);
    check("busy_rest_ignored", n, 21);
    check("period_ignored", period, 492);
    wait_reed(n);
    check("gap_ignored", n, 493);
    check("rev_ignored", rev_count, 5);

    // shorter period applied with cnt beyond it
    repeat (300) @(negedge clock);
    do_load(7'd60, 8'd200);
    wait_busy_fall(n, r);
    check("busy_len_60", n, 26);
    check("busy_reed_60", r, 0);
    check("reed_at_fall", reed, 0);
    check("period_60", period, 246);
    @(negedge clock);
    check("reed_after_fall", reed, 1);
    check("rev_after_fall", rev_count, 6);
    wait_reed(n);
    check("gap_60a", n, 247);
    wait_reed(n);
    check("gap_60b", n, 247);
    check("rev_60", rev_count, 8);

    // old-period pulse during the divide, cnt carried over
    repeat (230) @(negedge clock);
    do_load(7'd30, 8'd200);
    wait_busy_fall(n, r);
    check("busy_len_carry", n, 26);
    check("busy_reed_old", r, 1);
    check("period_carry", period, 492);
    wait_reed(n);
    check("gap_carry", n, 483);
    check("rev_carry", rev_count, 10);

    // reset mid-RUN
    repeat (100) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rrun_reed", reed, 0);
    check("rrun_busy", busy, 0);
    check("rrun_period", period, 0);
    check("rrun_rev", rev_count, 0);
    @(negedge clock);
    reset = 1'b1;
    count_reeds(600, r);
    check("rrun_no_reed", r, 0);

    // reset mid-DIVIDE
    do_load(7'd30, 8'd200);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rdiv_busy", busy, 0);
    check("rdiv_period", period, 0);
    @(negedge clock);
    reset = 1'b1;
    count_reeds(600, r);
    check("rdiv_no_reed", r, 0);
    check("rdiv_busy_idle", busy, 0);

    // first load after reset behaves as from IDLE
    do_load(7'd30, 8'd200);
    wait_busy_fall(n, r);
    check("rec_busy_len", n, 26);
    check("rec_period", period, 492);
    wait_reed(n);
    check("rec_gap", n, 493);
    check("rec_rev", rev_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
